// File: rtl/sub_seq_ctrl_if.sv
// sub_seq_ctrl_if: job request and result stream bundle for sub_seq_ctrl
interface sub_seq_ctrl_if #(
   parameter int NUM_INPUTS = 10,
   parameter int EXP_WIDTH  = 9,
   parameter int MANT_WIDTH = 8
);
   localparam int IDX_W = NUM_INPUTS > 1 ? $clog2(NUM_INPUTS) : 1;
   logic                             start;
   logic [EXP_WIDTH-1:0]             exp_sum;
   logic [NUM_INPUTS*MANT_WIDTH-1:0] input_bus;
   logic                             busy;
   logic                             out_valid;
   logic                             out_ready;
   logic [IDX_W-1:0]                 out_idx;
   logic [EXP_WIDTH-1:0]             out_data;
   logic                             done;
   modport master (output start, exp_sum, input_bus, out_ready,
                   input  busy, out_valid, out_idx, out_data, done);
   modport slave  (input  start, exp_sum, input_bus, out_ready,
                   output busy, out_valid, out_idx, out_data, done);
endinterface

// File: rtl/sub_seq_ctrl.sv
// sub_seq_ctrl: streams element[i] - exp_sum for a captured job; SUB_SEQ_SAT_EN clamps negative results to 0
module sub_seq_ctrl #(
   parameter int NUM_INPUTS = 10,
   parameter int EXP_WIDTH  = 9,
   parameter int MANT_WIDTH = 8
) (
   input logic           clk,
   input logic           rst_n,
   sub_seq_ctrl_if.slave bus
);
   localparam int IDX_W = NUM_INPUTS > 1 ? $clog2(NUM_INPUTS) : 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t                           state, state_nx;
   logic [NUM_INPUTS*MANT_WIDTH-1:0] data_q;
   logic [EXP_WIDTH-1:0]             exp_q, res_q, res_nx;
   logic [IDX_W-1:0]                 idx_q, idx_nx;
   logic                             capture, last;
   function automatic logic [EXP_WIDTH-1:0] diff(input logic [MANT_WIDTH-1:0] m, input logic [EXP_WIDTH-1:0] e);
      logic [EXP_WIDTH-1:0] x;
      x = EXP_WIDTH'(m);
`ifdef SUB_SEQ_SAT_EN
      return x < e ? '0 : x - e;
`else
      return x - e;
`endif
   endfunction
   always_comb begin
      state_nx = state;
      idx_nx   = idx_q;
      res_nx   = res_q;
      capture  = 1'b0;
      last     = idx_q == IDX_W'(NUM_INPUTS - 1);
      case (state)
         IDLE: if (bus.start) begin
            state_nx = RUN;
            idx_nx   = '0;
            res_nx   = diff(bus.input_bus[0 +: MANT_WIDTH], bus.exp_sum);
            capture  = 1'b1;
         end
         RUN: if (bus.out_ready) begin
            if (last) state_nx = DONE;
            else begin
               idx_nx = idx_q + 1'b1;
               res_nx = diff(data_q[int'(idx_nx)*MANT_WIDTH +: MANT_WIDTH], exp_q);
            end
         end
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state  <= IDLE;
         idx_q  <= '0;
         res_q  <= '0;
         exp_q  <= '0;
         data_q <= '0;
      end else begin
         state <= state_nx;
         idx_q <= idx_nx;
         res_q <= res_nx;
         if (capture) begin
            exp_q  <= bus.exp_sum;
            data_q <= bus.input_bus;
         end
      end
   assign bus.busy      = state != IDLE;
   assign bus.out_valid = state == RUN;
   assign bus.done      = state == DONE;
   assign bus.out_idx   = idx_q;
   assign bus.out_data  = res_q;
endmodule

// File: tb/tb_sub_seq_ctrl.sv
// tb_sub_seq_ctrl: directed vectors for sub_seq_ctrl
module tb_sub_seq_ctrl;
   logic clk = 1'b0, rst_n = 1'b0;
   int checks = 0, errors = 0, done_cnt;
   logic [79:0] v;
   logic [8:0]  obs [10];
   always #5 clk = ~clk;
   sub_seq_ctrl_if #(.NUM_INPUTS(10), .EXP_WIDTH(9), .MANT_WIDTH(8)) bus ();
   sub_seq_ctrl #(.NUM_INPUTS(10), .EXP_WIDTH(9), .MANT_WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   function automatic logic [8:0] ref_sub(input logic [7:0] m, input logic [8:0] e);
`ifdef SUB_SEQ_SAT_EN
      return {1'b0, m} < e ? 9'd0 : {1'b0, m} - e;
`else
      return {1'b0, m} - e;
`endif
   endfunction
   task automatic start_job(input logic [79:0] bv, input logic [8:0] e);
      @(negedge clk);
      bus.input_bus = bv;
      bus.exp_sum   = e;
      bus.start     = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask
   task automatic drain(input logic [79:0] bv, input logic [8:0] e);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         check("valid", 32'(bus.out_valid), 1);
         check("idx", 32'(bus.out_idx), i);
         check("data", 32'(bus.out_data), 32'(ref_sub(bv[i*8 +: 8], e)));
         obs[i] = bus.out_data;
         @(negedge clk);
      end
      check("done_pulse", 32'(bus.done), 1);
      check("valid_in_done", 32'(bus.out_valid), 0);
      @(negedge clk);
      check("done_low", 32'(bus.done), 0);
      check("idle_busy", 32'(bus.busy), 0);
   endtask
   initial begin
      bus.start = 1'b0;
      bus.out_ready = 1'b0;
      bus.exp_sum = '0;
      bus.input_bus = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_valid", 32'(bus.out_valid), 0);
      check("rst_done", 32'(bus.done), 0);
      check("rst_idx", 32'(bus.out_idx), 0);
      check("rst_data", 32'(bus.out_data), 0);
      rst_n = 1'b1;
      // scenario 1: 10..100 minus 5, done in the 11th cycle after start
      for (int i = 0; i < 10; i++) v[i*8 +: 8] = 8'(10 * (i + 1));
      bus.out_ready = 1'b1;
      start_job(v, 9'd5);
      for (int i = 0; i < 10; i++) begin
         check("s1_idx", 32'(bus.out_idx), i);
         check("s1_data", 32'(bus.out_data), 10 * i + 5);
         check("s1_nodone", 32'(bus.done), 0);
         @(negedge clk);
      end
      check("s1_done", 32'(bus.done), 1);
      @(negedge clk);
      check("s1_idle", 32'(bus.busy), 0);
      // scenario 2: element 3 below exp_sum
      for (int i = 0; i < 10; i++) v[i*8 +: 8] = 8'(20 + i);
      v[24 +: 8] = 8'd2;
      start_job(v, 9'd7);
      drain(v, 9'd7);
`ifdef SUB_SEQ_SAT_EN
      check("s2_idx3", 32'(obs[3]), 0);
`else
      check("s2_idx3", 32'(obs[3]), 507);
`endif
      check("s2_idx4", 32'(obs[4]), 17);
      // scenario 3: stall at idx 2
      for (int i = 0; i < 10; i++) v[i*8 +: 8] = 8'(40 + 3 * i);
      start_job(v, 9'd4);
      @(negedge clk);
      @(negedge clk);
      check("s3_idx2", 32'(bus.out_idx), 2);
      bus.out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("s3_hold_idx", 32'(bus.out_idx), 2);
         check("s3_hold_data", 32'(bus.out_data), 42);
         check("s3_hold_valid", 32'(bus.out_valid), 1);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("s3_idx3", 32'(bus.out_idx), 3);
      check("s3_data3", 32'(bus.out_data), 45);
      repeat (7) @(negedge clk);
      check("s3_done", 32'(bus.done), 1);
      @(negedge clk);
      // scenario 4: start ignored in RUN and DONE
      for (int i = 0; i < 10; i++) v[i*8 +: 8] = 8'(3 * i + 1);
      start_job(v, 9'd1);
      done_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         check("s4_idx", 32'(bus.out_idx), i);
         check("s4_data", 32'(bus.out_data), 3 * i);
         done_cnt += int'(bus.done);
         bus.start = i == 4;
         if (i == 4) begin
            bus.input_bus = {10{8'hFF}};
            bus.exp_sum = 9'd100;
         end
         @(negedge clk);
      end
      done_cnt += int'(bus.done);
      bus.start = 1'b1;
      bus.exp_sum = 9'd50;
      @(negedge clk);
      bus.start = 1'b0;
      check("s4_dropped", 32'(bus.busy), 0);
      done_cnt += int'(bus.done);
      @(negedge clk);
      check("s4_still_idle", 32'(bus.busy), 0);
      check("s4_one_done", 32'(done_cnt), 1);
      // scenario 5: reset mid-job
      for (int i = 0; i < 10; i++) v[i*8 +: 8] = 8'(7 * i + 2);
      start_job(v, 9'd3);
      repeat (5) @(negedge clk);
      check("s5_idx5", 32'(bus.out_idx), 5);
      rst_n = 1'b0;
      #1;
      check("s5_busy", 32'(bus.busy), 0);
      check("s5_valid", 32'(bus.out_valid), 0);
      check("s5_idx", 32'(bus.out_idx), 0);
      check("s5_data", 32'(bus.out_data), 0);
      done_cnt = 0;
      repeat (3) begin
         @(negedge clk);
         done_cnt += int'(bus.done);
      end
      check("s5_nodone", 32'(done_cnt), 0);
      rst_n = 1'b1;
      start_job(v, 9'd0);
      check("s5_first_idx", 32'(bus.out_idx), 0);
      check("s5_first_data", 32'(bus.out_data), 2);
      drain(v, 9'd0);
      check("s5_last", 32'(obs[9]), 65);
      // scenario 6: no sign extension
      v = {10{8'hFF}};
      start_job(v, 9'd0);
      drain(v, 9'd0);
      check("s6_data0", 32'(obs[0]), 255);
      check("s6_data9", 32'(obs[9]), 255);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/sub_seq_ctrl.md
SUB_SEQ_CTRL -- requirements
Module: sub_seq_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_INPUTS, default 10, the number of elements per job.
REQ-002 The block SHALL have parameter EXP_WIDTH, default 9, the result and exp_sum width in bits.
REQ-003 The block SHALL have parameter MANT_WIDTH, default 8, the input element width in bits.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit, the job request, sampled only in IDLE.
REQ-007 The block SHALL have port exp_sum, input, EXP_WIDTH bits, the subtrahend, captured on start.
REQ-008 The block SHALL have port input_bus, input, NUM_INPUTS*MANT_WIDTH bits; element i is bits [i*MANT_WIDTH +: MANT_WIDTH], captured on start.
REQ-009 The block SHALL have port busy, output, 1 bit, high in any state other than IDLE.
REQ-010 The block SHALL have port out_valid, output, 1 bit, result available.
REQ-011 The block SHALL have port out_ready, input, 1 bit, consumer accepts the result.
REQ-012 The block SHALL have port out_idx, output, clog2(NUM_INPUTS) bits (minimum 1), the element index of out_data.
REQ-013 The block SHALL have port out_data, output, EXP_WIDTH bits, the result for element out_idx.
REQ-014 The block SHALL have port done, output, 1 bit, a one-cycle pulse at job end.

Function
REQ-015 The block SHALL implement the states IDLE, RUN and DONE with one-hot or binary encoding.
REQ-016 In IDLE with start=1, the block SHALL capture exp_sum and input_bus, set the index to 0 and enter RUN on the same edge.
REQ-017 start SHALL be ignored in RUN and DONE; the captured operands SHALL NOT change until the next accepted start.
REQ-018 In RUN, out_valid SHALL be 1, and out_data SHALL equal zero-extended element[out_idx] minus the captured exp_sum, modulo 2^EXP_WIDTH; the result SHALL be registered, so the first result is valid one cycle after start.
REQ-019 A transfer SHALL occur on a rising edge where out_valid and out_ready are both 1; out_idx and out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-020 On a transfer with out_idx < NUM_INPUTS-1, the index SHALL increment, and the next result SHALL be presented in the following cycle with no bubble.
REQ-021 On a transfer with out_idx = NUM_INPUTS-1, the block SHALL enter DONE, and out_valid SHALL be 0 on the next cycle.
REQ-022 DONE SHALL last exactly one cycle with done=1, then return to IDLE; a start arriving in DONE SHALL be dropped.
REQ-023 With continuous out_ready=1, a job SHALL take NUM_INPUTS+2 cycles from start to return to IDLE.

Reset
REQ-024 rst_n=0 SHALL immediately force the state to IDLE, with busy=0, out_valid=0, done=0, out_idx=0, out_data=0, and the captured operands cleared to 0.
REQ-025 A reset in mid-job SHALL abandon the job; no done pulse SHALL be produced, and the first start after reset release SHALL begin a fresh job at index 0.

Configuration
REQ-026 With macro SUB_SEQ_SAT_EN defined, a negative difference (element < exp_sum, compared as unsigned EXP_WIDTH values) SHALL produce out_data=0.
REQ-027 Without SUB_SEQ_SAT_EN, out_data SHALL be the wrap-around difference of REQ-018, and no saturation logic SHALL be present.

Verification
REQ-028 Scenario 1: elements 0..9 = 10,20,...,100, exp_sum=5, out_ready held 1 -> out_data is 5,15,...,95 on idx 0..9 in consecutive cycles, and done pulses at cycle 11 after start.
REQ-029 Scenario 2: element 3 = 2, exp_sum=7, without SUB_SEQ_SAT_EN -> out_data at idx 3 is 507 (0x1FB); with SUB_SEQ_SAT_EN -> 0.
REQ-030 Scenario 3: out_ready held 0 for 4 cycles at idx 2 -> idx 2 and its data are stable throughout; after ready rises, idx 3 follows on the next cycle.
REQ-031 Scenario 4: start pulsed again during RUN and in DONE with different operands -> results are unchanged, and exactly one done pulse occurs.
REQ-032 Scenario 5: rst_n dropped at idx 5 -> outputs are 0 immediately, and there is no done pulse; a new start with exp_sum=0 yields out_data equal to the elements, starting from idx 0.
REQ-033 Scenario 6: all elements 255, exp_sum=0 -> every out_data is 255, with no sign extension.
